// File: rtl/video_timing_gen.sv
// video_timing_gen -- HDMI-side raster timing for the A2600 video path.
// Produces hs_n / vs_n / de and the pixel position for NTSC (858x525) or
// PAL (864x625) timing, phase-locked to the console through the analyzer's
// vreset pulse.
// Optional build macro: VTG_LOCK_DETECT_EN
//   defined   -> locked reports whether vreset pulses arrive in phase
//   undefined -> locked is tied low
module video_timing_gen #(
    parameter int N_H_ACT = 720,
    parameter int N_H_FP  = 16,
    parameter int N_H_SYN = 62,
    parameter int N_H_BP  = 60,
    parameter int N_V_ACT = 480,
    parameter int N_V_FP  = 9,
    parameter int N_V_SYN = 6,
    parameter int N_V_BP  = 30,
    parameter int P_H_ACT = 720,
    parameter int P_H_FP  = 12,
    parameter int P_H_SYN = 64,
    parameter int P_H_BP  = 68,
    parameter int P_V_ACT = 576,
    parameter int P_V_FP  = 5,
    parameter int P_V_SYN = 5,
    parameter int P_V_BP  = 39
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pal,
    input  logic        vreset,
    output logic        hs_n,
    output logic        vs_n,
    output logic        de,
    output logic [11:0] hpos,
    output logic [10:0] vpos,
    output logic        frame_start,
    output logic        pal_active,
    output logic        locked
);

    // Per-mode limits, pre-sized to the counter widths.
    localparam logic [11:0] N_H_TOT  = 12'(N_H_ACT + N_H_FP + N_H_SYN + N_H_BP);
    localparam logic [11:0] P_H_TOT  = 12'(P_H_ACT + P_H_FP + P_H_SYN + P_H_BP);
    localparam logic [10:0] N_V_TOT  = 11'(N_V_ACT + N_V_FP + N_V_SYN + N_V_BP);
    localparam logic [10:0] P_V_TOT  = 11'(P_V_ACT + P_V_FP + P_V_SYN + P_V_BP);

    localparam logic [11:0] N_H_ACTV = 12'(N_H_ACT);
    localparam logic [11:0] P_H_ACTV = 12'(P_H_ACT);
    localparam logic [10:0] N_V_ACTV = 11'(N_V_ACT);
    localparam logic [10:0] P_V_ACTV = 11'(P_V_ACT);

    localparam logic [11:0] N_HS_BEG = 12'(N_H_ACT + N_H_FP);
    localparam logic [11:0] N_HS_END = 12'(N_H_ACT + N_H_FP + N_H_SYN);
    localparam logic [11:0] P_HS_BEG = 12'(P_H_ACT + P_H_FP);
    localparam logic [11:0] P_HS_END = 12'(P_H_ACT + P_H_FP + P_H_SYN);
    localparam logic [10:0] N_VS_BEG = 11'(N_V_ACT + N_V_FP);
    localparam logic [10:0] N_VS_END = 11'(N_V_ACT + N_V_FP + N_V_SYN);
    localparam logic [10:0] P_VS_BEG = 11'(P_V_ACT + P_V_FP);
    localparam logic [10:0] P_VS_END = 11'(P_V_ACT + P_V_FP + P_V_SYN);

    // State registers
    logic [11:0] r_hcnt;
    logic [10:0] r_vcnt;
    logic        r_pal_q;
    logic        r_vreset_q;
    logic        r_hs_n;
    logic        r_vs_n;
    logic        r_de;
    logic        r_frame_start;

    // Combinational next-state
    logic [11:0] w_h_tot_cur;
    logic [10:0] w_v_tot_cur;
    logic        w_h_last;
    logic        w_v_last;
    logic        w_wrap;
    logic [11:0] w_hcnt_next;
    logic [10:0] w_vcnt_next;
    logic        w_pal_next;
    logic        w_frame_start_next;

    // Decode limits for the mode that will be in effect after this edge
    logic [11:0] w_h_act;
    logic [11:0] w_hs_beg;
    logic [11:0] w_hs_end;
    logic [10:0] w_v_act;
    logic [10:0] w_vs_beg;
    logic [10:0] w_vs_end;
    logic        w_de_next;
    logic        w_hs_n_next;
    logic        w_vs_n_next;

    // Wrap detection uses ">= total-1" so a raster left out of range by a
    // mode change still folds back to (0,0) instead of running to overflow.
    always_comb begin
        w_h_tot_cur = r_pal_q ? P_H_TOT : N_H_TOT;
        w_v_tot_cur = r_pal_q ? P_V_TOT : N_V_TOT;
        w_h_last    = (r_hcnt >= (w_h_tot_cur - 12'd1));
        w_v_last    = (r_vcnt >= (w_v_tot_cur - 11'd1));
        w_wrap      = w_h_last && w_v_last;
    end

    // Counter advance: vreset and the natural end of frame both land on (0,0)
    // and are the only points where the pal request is taken into effect.
    always_comb begin
        w_hcnt_next = r_hcnt + 12'd1;
        w_vcnt_next = r_vcnt;
        w_pal_next  = r_pal_q;
        if (vreset || w_wrap) begin
            w_hcnt_next = '0;
            w_vcnt_next = '0;
            w_pal_next  = pal;
        end else if (w_h_last) begin
            w_hcnt_next = '0;
            w_vcnt_next = r_vcnt + 11'd1;
        end
    end

    // One frame_start per entry into (0,0); a held vreset only counts once.
    always_comb begin
        w_frame_start_next = w_wrap || (vreset && !r_vreset_q);
    end

    // Sync / enable decode of the next-state position with next-state mode.
    always_comb begin
        w_h_act     = w_pal_next ? P_H_ACTV : N_H_ACTV;
        w_hs_beg    = w_pal_next ? P_HS_BEG : N_HS_BEG;
        w_hs_end    = w_pal_next ? P_HS_END : N_HS_END;
        w_v_act     = w_pal_next ? P_V_ACTV : N_V_ACTV;
        w_vs_beg    = w_pal_next ? P_VS_BEG : N_VS_BEG;
        w_vs_end    = w_pal_next ? P_VS_END : N_VS_END;
        w_de_next   = (w_hcnt_next < w_h_act) && (w_vcnt_next < w_v_act);
        w_hs_n_next = !((w_hcnt_next >= w_hs_beg) && (w_hcnt_next < w_hs_end));
        w_vs_n_next = !((w_vcnt_next >= w_vs_beg) && (w_vcnt_next < w_vs_end));
    end

    // Raster state and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hcnt        <= '0;
            r_vcnt        <= '0;
            r_pal_q       <= 1'b0;
            r_vreset_q    <= 1'b0;
            r_hs_n        <= 1'b1;
            r_vs_n        <= 1'b1;
            r_de          <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_hcnt        <= w_hcnt_next;
            r_vcnt        <= w_vcnt_next;
            r_pal_q       <= w_pal_next;
            r_vreset_q    <= vreset;
            r_hs_n        <= w_hs_n_next;
            r_vs_n        <= w_vs_n_next;
            r_de          <= w_de_next;
            r_frame_start <= w_frame_start_next;
        end
    end

`ifdef VTG_LOCK_DETECT_EN
    logic r_locked;
    logic r_idle_frame;

    // An in-phase vreset coincides with the natural wrap and sets locked;
    // any other vreset, or a second unsynchronised frame end, clears it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_locked     <= 1'b0;
            r_idle_frame <= 1'b0;
        end else if (vreset) begin
            r_locked     <= w_wrap;
            r_idle_frame <= 1'b0;
        end else if (w_wrap) begin
            if (r_idle_frame) begin
                r_locked <= 1'b0;
            end
            r_idle_frame <= 1'b1;
        end
    end

    assign locked = r_locked;
`else
    assign locked = 1'b0;
`endif

    assign hs_n        = r_hs_n;
    assign vs_n        = r_vs_n;
    assign de          = r_de;
    assign hpos        = r_hcnt;
    assign vpos        = r_vcnt;
    assign frame_start = r_frame_start;
    assign pal_active  = r_pal_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Testbench for video_timing_gen, using reduced raster sizes so whole frames
// fit in a short run. Expected outputs come from a linear-pixel-index model.
module tb_video_timing_gen;

    localparam int NHA = 8,  NHF = 2, NHS = 3, NHB = 2;
    localparam int NVA = 4,  NVF = 1, NVS = 2, NVB = 1;
    localparam int PHA = 10, PHF = 1, PHS = 3, PHB = 2;
    localparam int PVA = 6,  PVF = 1, PVS = 1, PVB = 2;
    localparam int NHT = NHA + NHF + NHS + NHB;   // 15
    localparam int NVT = NVA + NVF + NVS + NVB;   // 8
    localparam int PHT = PHA + PHF + PHS + PHB;   // 16
    localparam int PVT = PVA + PVF + PVS + PVB;   // 10

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        pal = 1'b0;
    logic        vreset = 1'b0;
    logic        hs_n, vs_n, de, frame_start, pal_active, locked;
    logic [11:0] hpos;
    logic [10:0] vpos;

    video_timing_gen #(
        .N_H_ACT(NHA), .N_H_FP(NHF), .N_H_SYN(NHS), .N_H_BP(NHB),
        .N_V_ACT(NVA), .N_V_FP(NVF), .N_V_SYN(NVS), .N_V_BP(NVB),
        .P_H_ACT(PHA), .P_H_FP(PHF), .P_H_SYN(PHS), .P_H_BP(PHB),
        .P_V_ACT(PVA), .P_V_FP(PVF), .P_V_SYN(PVS), .P_V_BP(PVB)
    ) dut (
        .clk(clk), .reset_n(reset_n), .pal(pal), .vreset(vreset),
        .hs_n(hs_n), .vs_n(vs_n), .de(de), .hpos(hpos), .vpos(vpos),
        .frame_start(frame_start), .pal_active(pal_active), .locked(locked)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        hs_n;
        logic        vs_n;
        logic        de;
        logic [11:0] hpos;
        logic [10:0] vpos;
        logic        fs;
        logic        pa;
        logic        lk;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    int   pushed = 0;
    int   popped = 0;

    // Reference model: position is a single pixel index inside the frame.
    int   m_pos = 0;
    bit   m_pal = 1'b0;
    bit   m_prev = 1'b0;
    bit   m_locked = 1'b0;
    int   m_idle = 0;

    task automatic model_push();
        exp_t e;
        int   ht, vt, x, y, ha, hf, hsy, va, vf, vsy;
        bit   nat;
        if (!reset_n) begin
            m_pos = 0; m_pal = 1'b0; m_prev = 1'b0; m_locked = 1'b0; m_idle = 0;
            e.hs_n = 1'b1; e.vs_n = 1'b1; e.de = 1'b0; e.hpos = '0; e.vpos = '0;
            e.fs = 1'b0; e.pa = 1'b0; e.lk = 1'b0;
        end else begin
            ht  = m_pal ? PHT : NHT;
            vt  = m_pal ? PVT : NVT;
            nat = (m_pos == ht * vt - 1);
            e.fs = nat || (vreset && !m_prev);
            if (vreset || nat) begin
                m_pos = 0;
                m_pal = pal;
            end else begin
                m_pos = m_pos + 1;
            end
`ifdef VTG_LOCK_DETECT_EN
            if (vreset) begin
                m_locked = nat;
                m_idle   = 0;
            end else if (nat) begin
                m_idle = m_idle + 1;
                if (m_idle >= 2) m_locked = 1'b0;
            end
`endif
            m_prev = vreset;
            ht  = m_pal ? PHT : NHT;
            ha  = m_pal ? PHA : NHA;  hf = m_pal ? PHF : NHF;  hsy = m_pal ? PHS : NHS;
            va  = m_pal ? PVA : NVA;  vf = m_pal ? PVF : NVF;  vsy = m_pal ? PVS : NVS;
            x   = m_pos % ht;
            y   = m_pos / ht;
            e.hpos = 12'(x);
            e.vpos = 11'(y);
            e.de   = (x < ha) && (y < va);
            e.hs_n = !((x >= ha + hf) && (x < ha + hf + hsy));
            e.vs_n = !((y >= va + vf) && (y < va + vf + vsy));
            e.pa   = m_pal;
            e.lk   = m_locked;
        end
        sb_q.push_back(e);
        pushed++;
    endtask

    // One stimulus cycle: drive at the falling edge, queue the expectation.
    task automatic cyc(input logic rn, input logic p, input logic vr);
        @(negedge clk);
        reset_n = rn;
        pal     = p;
        vreset  = vr;
        model_push();
    endtask

    // Free-run until the model reaches a pixel index (bounded).
    task automatic run_to(input int target);
        int n;
        n = 0;
        while (m_pos != target && n < 1000) begin
            cyc(1'b1, pal, 1'b0);
            n++;
        end
        if (n >= 1000) begin
            checks++;
            errors++;
            $display("FAIL run_to: position %0d not reached, at %0d", target, m_pos);
        end
    endtask

    // Monitor: every cycle the DUT presents a pixel; compare with the queue.
    exp_t mon_e;
    exp_t mon_a;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                popped++;
                mon_a = '{hs_n: hs_n, vs_n: vs_n, de: de, hpos: hpos, vpos: vpos,
                          fs: frame_start, pa: pal_active, lk: locked};
                checks++;
                if (mon_a !== mon_e) begin
                    errors++;
                    $display("FAIL raster t=%0t got hs=%b vs=%b de=%b h=%0d v=%0d fs=%b pa=%b lk=%b want hs=%b vs=%b de=%b h=%0d v=%0d fs=%b pa=%b lk=%b",
                             $time, mon_a.hs_n, mon_a.vs_n, mon_a.de, mon_a.hpos, mon_a.vpos,
                             mon_a.fs, mon_a.pa, mon_a.lk, mon_e.hs_n, mon_e.vs_n, mon_e.de,
                             mon_e.hpos, mon_e.vpos, mon_e.fs, mon_e.pa, mon_e.lk);
                end else begin
                    $display("pix t=%0t h=%0d v=%0d de=%b hs=%b vs=%b fs=%b pa=%b lk=%b",
                             $time, mon_a.hpos, mon_a.vpos, mon_a.de, mon_a.hs_n,
                             mon_a.vs_n, mon_a.fs, mon_a.pa, mon_a.lk);
                end
            end
        end
    end

    logic p_rand;
    logic v_rand;
    initial begin
        // Reset, then NTSC free-run for two frames and a bit.
        repeat (3) cyc(1'b0, 1'b0, 1'b0);
        repeat (2 * NHT * NVT + 20) cyc(1'b1, 1'b0, 1'b0);

        // pal request mid-frame: takes effect only at the next wrap.
        repeat (2 * PHT * PVT + NHT * NVT) cyc(1'b1, 1'b1, 1'b0);

        // vreset in PAL at a line beyond the NTSC frame, switching to NTSC.
        run_to(8 * PHT + 3);
        cyc(1'b1, 1'b0, 1'b1);
        repeat (10) cyc(1'b1, 1'b0, 1'b0);

        // Mid-frame vreset in NTSC, then a full frame to the next frame_start.
        run_to(2 * NHT + 5);
        cyc(1'b1, 1'b0, 1'b1);
        repeat (NHT * NVT + 5) cyc(1'b1, 1'b0, 1'b0);

        // vreset held for three cycles keeps the raster pinned at (0,0).
        repeat (3) cyc(1'b1, 1'b0, 1'b1);
        repeat (5) cyc(1'b1, 1'b0, 1'b0);

        // vreset exactly at the natural wrap, then one out of phase.
        run_to(NHT * NVT - 1);
        cyc(1'b1, 1'b0, 1'b1);
        repeat (20) cyc(1'b1, 1'b0, 1'b0);
        run_to(5);
        cyc(1'b1, 1'b0, 1'b1);

        // In phase again, then let frames elapse with no vreset.
        run_to(NHT * NVT - 1);
        cyc(1'b1, 1'b0, 1'b1);
        repeat (3 * NHT * NVT) cyc(1'b1, 1'b0, 1'b0);

        // Randomized mode requests and vreset pulses.
        p_rand = 1'b0;
        repeat (1500) begin
            v_rand = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 199) == 0) p_rand = ~p_rand;
            cyc(1'b1, p_rand, v_rand);
        end

        // Asynchronous reset mid-line: outputs drop before any clock edge.
        cyc(1'b1, 1'b0, 1'b1);
        run_to(7);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        model_push();
        #1;
        checks++;
        if ({hs_n, vs_n, de, hpos, vpos, frame_start, pal_active, locked} !==
            {1'b1, 1'b1, 1'b0, 12'd0, 11'd0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: got hs=%b vs=%b de=%b h=%0d v=%0d fs=%b pa=%b lk=%b, want reset values",
                     hs_n, vs_n, de, hpos, vpos, frame_start, pal_active, locked);
        end else begin
            $display("async reset t=%0t outputs at reset values", $time);
        end
        repeat (2) cyc(1'b0, 1'b0, 1'b0);
        repeat (6) cyc(1'b1, 1'b0, 1'b0);

        // Let the monitor drain the last expectation.
        @(posedge clk);
        #3;
        checks++;
        if (sb_q.size() != 0 || popped != pushed) begin
            errors++;
            $display("FAIL scoreboard_drain: popped %0d of %0d, %0d left", popped, pushed, sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
